// File: rtl/prog_loader.sv
// Serial program loader: big-endian count + word stream into instruction memory.
// Optional checksum byte after the data when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERR
    } state_t;

    localparam logic [11:0] MAXW = 12'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [10:0] idx_q, idx_d;
    logic [7:0]  hi_q, hi_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic [10:0] n_new;
    logic [10:0] idx_inc;

    assign byte_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                        (state_q == S_DAT_HI) || (state_q == S_DAT_LO)
`ifdef LOADER_CHECKSUM_EN
                        || (state_q == S_CHK)
`endif
                        ;
    assign accept  = byte_valid && byte_ready;
    assign n_new   = {cnt_q[10:8], byte_in};
    assign idx_inc = idx_q + 11'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_CNT_HI;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    // Only 3 bits of the high count byte fit; anything above is out of range.
                    cnt_d   = {byte_in[2:0], 8'h00};
                    ovf_d   = |byte_in[7:3];
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d = n_new;
                    if (ovf_q || ({1'b0, n_new} > MAXW))
                        state_d = S_ERR;
                    else if (n_new == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
`endif
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[9:0];
                    wdata_d = {hi_q, byte_in};
                    idx_d   = idx_inc;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_in;
                    state_d = (idx_inc < cnt_q) ? S_DAT_HI : S_CHK;
`else
                    state_d = (idx_inc < cnt_q) ? S_DAT_HI : S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept)
                    state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign done_d = (state_d == S_DONE);
    assign err_d  = (state_d == S_ERR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = done_q;
    assign error      = err_q;
endmodule
